muldiv_unit: RTL

//  Iterative multi-cycle M-extension engine sitting downstream of the ALU control decode, beside
//  the single-cycle ALU in EX. Consumes the 5-bit ALU op codes MUL..REMU and executes them over
//  NB_DATA+1 cycles (1 for special cases). Exposes busy/done so the hazard unit can stall the pipe.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter_core.sv | 65 ++++++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide engine.
//  - ALU operation codes, common with the ALU control decode.
//  - State encoding of the multi-cycle engine FSM.
package muldiv_pkg;

  localparam int ALU_OP_W = 5;

  // Base integer ops (executed by the single-cycle ALU, ignored here)
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'b01001;
  // M-extension ops (executed by muldiv_unit)
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'b01111;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle datapath of the iterative multiply/divide engine.
// Operates on unsigned magnitudes; sign handling lives in the top.
//  Multiply : radix-2 shift-add, multiplier in lo, multiplicand in opnd,
//             product accumulates into {hi, lo} while lo shifts out.
//  Divide   : restoring radix-2, dividend in lo, divisor in opnd,
//             remainder builds in hi, quotient bits shift into lo MSB first.
// Ports:
//  i_clk, i_rst        clock, asynchronous active-high reset
//  i_load              capture operand magnitudes (clears hi)
//  i_step              perform one iteration
//  i_is_div            selects restore-subtract instead of shift-add
//  i_a_mag, i_b_mag    operand magnitudes (a = multiplier/dividend)
//  o_hi_nxt, o_lo_nxt  value of {hi, lo} after the current iteration
module muldiv_iter_core #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [NB_DATA-1:0] i_a_mag,
  input  logic [NB_DATA-1:0] i_b_mag,
  output logic [NB_DATA-1:0] o_hi_nxt,
  output logic [NB_DATA-1:0] o_lo_nxt
);

  logic [NB_DATA-1:0] hi_q, lo_q, opnd_q;
  logic [NB_DATA:0]   add_sum, shifted, diff;

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[NB_DATA-1]};
    // hi < divisor is invariant, so shifted < 2*divisor: diff MSB is the borrow.
    diff    = shifted - {1'b0, opnd_q};
    if (i_is_div) begin
      if (diff[NB_DATA]) begin
        o_hi_nxt = shifted[NB_DATA-1:0];
        o_lo_nxt = {lo_q[NB_DATA-2:0], 1'b0};
      end else begin
        o_hi_nxt = diff[NB_DATA-1:0];
        o_lo_nxt = {lo_q[NB_DATA-2:0], 1'b1};
      end
    end else begin
      o_hi_nxt = add_sum[NB_DATA:1];
      o_lo_nxt = {add_sum[0], lo_q[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (i_load) begin
      hi_q   <= '0;
      lo_q   <= i_a_mag;
      opnd_q <= i_b_mag;
    end else if (i_step) begin
      hi_q   <= o_hi_nxt;
      lo_q   <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multi-cycle M-extension engine (MUL..REMU).
// Handshake: i_start is sampled only while idle (o_busy=0); an accepted
// request raises o_busy on the next edge and keeps it high until the engine
// returns to idle; the result is presented with a one-cycle o_done pulse in
// the first idle cycle and o_result holds until the next completion.
// Requests during busy are dropped, not queued.
// Ports:
//  i_clk, i_rst        clock, asynchronous active-high reset
//  i_start             operation request
//  i_flush             abort in-flight operation
//  i_alu_op            ALU op code (only MUL..REMU accepted)
//  i_op_a, i_op_b      rs1 / rs2 values
//  o_result            result, valid with o_done
//  o_done              one-cycle completion pulse
//  o_busy              engine not idle
//  o_dbg_state         current FSM state
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_flush,
  input  logic [NB_OP-1:0]   i_alu_op,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_done,
  output logic               o_busy,
  output md_state_e          o_dbg_state
);

  localparam int CNT_W = $clog2(NB_DATA);
  localparam logic [NB_DATA-1:0] A_MIN = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(NB_DATA-1);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, is_rem_q, is_lo_q, neg_q;
  logic [NB_DATA-1:0] res_q, result_q;
  logic               done_q;

  // Op decode of the incoming request
  logic op_mul, op_mulh, op_mulhsu, op_div, op_divu, op_rem, op_remu, op_valid;
  assign op_mul    = (i_alu_op == NB_OP'(ALU_MUL));
  assign op_mulh   = (i_alu_op == NB_OP'(ALU_MULH));
  assign op_mulhsu = (i_alu_op == NB_OP'(ALU_MULHSU));
  assign op_div    = (i_alu_op == NB_OP'(ALU_DIV));
  assign op_divu   = (i_alu_op == NB_OP'(ALU_DIVU));
  assign op_rem    = (i_alu_op == NB_OP'(ALU_REM));
  assign op_remu   = (i_alu_op == NB_OP'(ALU_REMU));
  assign op_valid  = (i_alu_op >= NB_OP'(ALU_MUL)) && (i_alu_op <= NB_OP'(ALU_REMU));

  // Sign preparation
  logic               a_neg, b_neg, is_div_op, is_rem_op, neg_res;
  logic [NB_DATA-1:0] a_mag, b_mag;
  assign a_neg     = (op_mulh | op_mulhsu | op_div | op_rem) & i_op_a[NB_DATA-1];
  assign b_neg     = (op_mulh | op_div | op_rem) & i_op_b[NB_DATA-1];
  assign a_mag     = a_neg ? -i_op_a : i_op_a;
  assign b_mag     = b_neg ? -i_op_b : i_op_b;
  assign is_div_op = op_div | op_divu | op_rem | op_remu;
  assign is_rem_op = op_rem | op_remu;
  // Remainder takes the dividend's sign; product/quotient the xor of both.
  assign neg_res   = is_rem_op ? a_neg : (a_neg ^ b_neg);

  // Divide special cases resolved without iterating
  logic               div_zero, div_ovf, special;
  logic [NB_DATA-1:0] special_res;
  assign div_zero    = (i_op_b == '0);
  assign div_ovf     = (op_div | op_rem) & (i_op_a == A_MIN) & (i_op_b == '1);
  assign special     = is_div_op & (div_zero | div_ovf);
  assign special_res = div_zero ? (is_rem_op ? i_op_a : '1)
                                : (is_rem_op ? '0 : i_op_a);

  logic accept, step;
  assign accept = (state_q == ST_IDLE) & i_start & ~i_flush & op_valid;
  assign step   = (state_q == ST_CALC) & ~i_flush;

  logic [NB_DATA-1:0] hi_nxt, lo_nxt;

  muldiv_iter_core #(.NB_DATA(NB_DATA)) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (accept),
    .i_step   (step),
    .i_is_div (is_div_q),
    .i_a_mag  (a_mag),
    .i_b_mag  (b_mag),
    .o_hi_nxt (hi_nxt),
    .o_lo_nxt (lo_nxt)
  );

  // Sign post-fix, applied to the value produced by the final iteration
  logic [2*NB_DATA-1:0] prod_raw, prod_fix;
  logic [NB_DATA-1:0]   div_raw, div_fix, final_res;
  always_comb begin
    prod_raw  = {hi_nxt, lo_nxt};
    prod_fix  = neg_q ? -prod_raw : prod_raw;
    div_raw   = is_rem_q ? hi_nxt : lo_nxt;
    div_fix   = neg_q ? -div_raw : div_raw;
    final_res = is_div_q ? div_fix
                         : (is_lo_q ? prod_fix[NB_DATA-1:0] : prod_fix[2*NB_DATA-1:NB_DATA]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      is_lo_q  <= 1'b0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_div_q <= is_div_op;
            is_rem_q <= is_rem_op;
            is_lo_q  <= op_mul;
            neg_q    <= neg_res;
            cnt_q    <= '0;
            if (special) begin
              res_q   <= special_res;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            res_q   <= final_res;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Publishing happens on leaving DONE so a flush here leaves o_result untouched.
          state_q <= ST_IDLE;
          if (!i_flush) begin
            result_q <= res_q;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_result    = result_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule
